// File: rtl/mips_pkg.sv
// Shared types and constants for the mips memory responder.
// Holds the boot/run state type, word-size constants and the address decode helper.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / 8;

  localparam logic [WORD_W-1:0] IO_ADDR_DEF = 32'hFFFF_FFFC;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic is_io;
    logic in_range;
    logic aligned;
  } addr_dec_t;

  // in_range means every bit above the RAM word index is zero
  function automatic addr_dec_t decode_addr(input logic [WORD_W-1:0] addr,
                                            input logic [WORD_W-1:0] io_addr,
                                            input int              aw);
    addr_dec_t d;
    d.is_io    = (addr == io_addr);
    d.in_range = ((addr >> (aw + 2)) == '0);
    d.aligned  = (addr[1:0] == 2'b00);
    return d;
  endfunction

endpackage

// File: rtl/mips_ram.sv
// DEPTH x 32 word RAM: synchronous write, asynchronous (0-cycle) read.
// No backpressure; a write with we high always lands on the rising edge.
module mips_ram
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem.sv
// Unified instruction/data memory for the multicycle mips core, with a boot loader and one IO register.
// Reads are combinational; stores land on the edge; load_ready is high for the whole LOAD phase.
module mips_mem
  import mips_pkg::*;
#(
  parameter int                DEPTH   = 64,
  parameter logic [WORD_W-1:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writedata,
  input  logic              memwrite,
  output logic [WORD_W-1:0] readdata,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic [WORD_W-1:0] io_out,
  output logic              io_strobe,
  output logic              misalign_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  mem_state_t        state, state_nxt;
  logic [AW-1:0]     load_ptr;
  addr_dec_t         dec;
  logic              in_run;
  logic              load_fire;
  logic              core_we, io_we, misalign_we;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  assign dec        = decode_addr(address, IO_ADDR, AW);
  assign in_run     = (state == RUN);
  assign load_ready = (state == LOAD);
  assign load_fire  = load_ready & load_valid;

  // IO decode takes priority so an IO_ADDR that aliases into RAM never writes the array
  assign io_we       = in_run & memwrite & dec.aligned & dec.is_io;
  assign core_we     = in_run & memwrite & dec.aligned & ~dec.is_io & dec.in_range;
  assign misalign_we = in_run & memwrite & ~dec.aligned;

  // Loader and core are never active together, so the mux is just a phase select
  assign ram_we    = load_fire | core_we;
  assign ram_waddr = load_fire ? load_ptr : address[AW+1:2];
  assign ram_wdata = load_fire ? load_data : writedata;

  mips_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (address[AW+1:2]),
    .rdata (ram_rdata)
  );

  always_comb begin
    if (dec.is_io)         readdata = io_out;
    else if (dec.in_range) readdata = ram_rdata;
    else                   readdata = '0;
  end

  // Loading stops at the top word even without load_last, so the pointer never wraps
  always_comb begin
    state_nxt = state;
    if (load_fire && (load_last || load_ptr == LAST_PTR)) state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      load_ptr     <= '0;
      cpu_reset    <= 1'b1;
      io_out       <= '0;
      io_strobe    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_reset <= (state_nxt == LOAD);
      io_strobe <= io_we;
      if (load_fire)   load_ptr     <= load_ptr + 1'b1;
      if (io_we)       io_out       <= writedata;
      if (misalign_we) misalign_err <= 1'b1;
    end
  end

endmodule
